alu_seq: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes and a persistent Z,N,C,V condition register.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq_mul.sv | 60 ++++++
 rtl/alu_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_seq.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, condition-flag
// bit positions and FSM state encoding.
package alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_ZERO = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_W-1:0] OP_NEG  = 4'h3;
  localparam logic [OP_W-1:0] OP_AND  = 4'h4;
  localparam logic [OP_W-1:0] OP_OR   = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h6;
  localparam logic [OP_W-1:0] OP_NOT  = 4'h7;
  localparam logic [OP_W-1:0] OP_MUL  = 4'h8;
  localparam logic [OP_W-1:0] OP_MOVB = 4'h9;
  localparam logic [OP_W-1:0] OP_SHL  = 4'hA;
  localparam logic [OP_W-1:0] OP_SHR  = 4'hB;
  localparam logic [OP_W-1:0] OP_ROL  = 4'hC;
  localparam logic [OP_W-1:0] OP_ROR  = 4'hD;
  localparam logic [OP_W-1:0] OP_ADD4 = 4'hE;
  localparam logic [OP_W-1:0] OP_CMP  = 4'hF;

  // Bit positions inside the {Z,N,C,V} condition register
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for alu_seq.
//  in_valid/in_ready : operation handshake carrying a, b, alu_op
//  out_valid/out_ready : result handshake carrying result, cond, illegal
//  master = producer of operations / consumer of results; slave = the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [OP_W-1:0]   alu_op;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic [FLAG_W-1:0] cond;
  logic              illegal;

  modport master (
    output in_valid, a, b, alu_op, out_ready,
    input  in_ready, out_valid, result, cond, illegal
  );

  modport slave (
    input  in_valid, a, b, alu_op, out_ready,
    output in_ready, out_valid, result, cond, illegal
  );

endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier.
//  clk, reset : clock, synchronous active-high reset (aborts a running multiply)
//  start      : load a/b and perform the first partial-product step
//  a, b       : multiplicand / multiplier
//  done       : product valid (one-cycle pulse, WIDTH-1 cycles after start)
//  product    : 2*WIDTH-bit product
module alu_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               busy;

  // One step: add multiplicand into the upper half when the multiplier LSB
  // (acc[0]) is set, then shift the whole accumulator right by one.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] s;
    s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {s, p[WIDTH-1:1]};
  endfunction

  // First step happens on the start edge so the product is ready after WIDTH steps
  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
    end else if (start) begin
      mcand <= a;
      acc   <= mul_step({{WIDTH{1'b0}}, b}, a);
      cnt   <= CNT_W'(WIDTH - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        acc <= mul_step(acc, mcand);
        cnt <= cnt - CNT_W'(1);
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done    = busy & (cnt == '0);
  assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a persistent {Z,N,C,V}
// condition register. Single-cycle ops complete one cycle after accept;
// MUL (when enabled) completes WIDTH+1 cycles after accept.
//  clk, reset : clock, synchronous active-high reset
//  bus        : alu_seq_if slave (operation in, result/cond/illegal out)
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  alu_seq_if.slave    bus
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t              state;
  logic                valid_q;
  logic [WIDTH-1:0]    result_q;
  logic [FLAG_W-1:0]   cond_q;
  logic                illegal_q;

  logic                accept;
  logic [WIDTH-1:0]    add_b;
  logic [WIDTH:0]      add_s;
  logic [WIDTH:0]      sub_s;
  logic [WIDTH-1:0]    res_c;
  logic [WIDTH-1:0]    zn_src_c;
  logic                c_c;
  logic                v_c;
  logic                illegal_c;
  logic                is_mul_c;
  logic [FLAG_W-1:0]   flags_c;
  logic [FLAG_W-1:0]   mul_flags_c;
  logic                mul_done;
  logic [2*WIDTH-1:0]  mul_prod;

  assign bus.in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.result    = result_q;
  assign bus.cond      = cond_q;
  assign bus.illegal   = illegal_q;

  // Shared adder (ADD/ADD4) and subtractor (SUB/CMP)
  assign add_b = (bus.alu_op == OP_ADD4) ? WIDTH'(4) : bus.b;
  assign add_s = {1'b0, bus.a} + {1'b0, add_b};
  assign sub_s = {1'b0, bus.a} - {1'b0, bus.b};

  // Single-cycle result and flags from the live operands
  always_comb begin
    res_c     = '0;
    c_c       = 1'b0;
    v_c       = 1'b0;
    illegal_c = 1'b0;
    is_mul_c  = 1'b0;
    case (bus.alu_op)
      OP_ZERO: res_c = '0;
      OP_ADD, OP_ADD4: begin
        res_c = add_s[WIDTH-1:0];
        c_c   = add_s[WIDTH];
        v_c   = (bus.a[WIDTH-1] == add_b[WIDTH-1]) & (add_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res_c = sub_s[WIDTH-1:0];
        c_c   = ~sub_s[WIDTH];
        v_c   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (sub_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_NEG: begin
        res_c = '0 - bus.b;
        c_c   = (bus.b == '0);
        v_c   = (bus.b == MIN_NEG);
      end
      OP_AND:  res_c = bus.a & bus.b;
      OP_OR:   res_c = bus.a | bus.b;
      OP_XOR:  res_c = bus.a ^ bus.b;
      OP_NOT:  res_c = ~bus.b;
      OP_MOVB: res_c = bus.b;
      OP_MUL: begin
        if (MUL_EN) is_mul_c  = 1'b1;
        else        illegal_c = 1'b1;
      end
      OP_SHL: begin
        res_c = {bus.a[WIDTH-2:0], 1'b0};
        c_c   = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        res_c = {1'b0, bus.a[WIDTH-1:1]};
        c_c   = bus.a[0];
      end
      OP_ROL: begin
        res_c = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
        c_c   = bus.a[WIDTH-1];
      end
      OP_ROR: begin
        res_c = {bus.a[0], bus.a[WIDTH-1:1]};
        c_c   = bus.a[0];
      end
      default: res_c = '0;
    endcase

    // CMP reports a-b flags but passes a through as the result
    zn_src_c = res_c;
    if (bus.alu_op == OP_CMP) res_c = bus.a;

    flags_c         = '0;
    flags_c[FLAG_Z] = (zn_src_c == '0);
    flags_c[FLAG_N] = zn_src_c[WIDTH-1];
    flags_c[FLAG_C] = c_c;
    flags_c[FLAG_V] = v_c;
  end

  // MUL flags: C and V both signal a non-zero upper product half
  always_comb begin
    mul_flags_c         = '0;
    mul_flags_c[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
    mul_flags_c[FLAG_N] = mul_prod[WIDTH-1];
    mul_flags_c[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
    mul_flags_c[FLAG_V] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
  end

  if (MUL_EN) begin : g_mul
    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (accept & is_mul_c),
      .a       (bus.a),
      .b       (bus.b),
      .done    (mul_done),
      .product (mul_prod)
    );
  end else begin : g_no_mul
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  // Control FSM; result/cond/illegal change only on entry to DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      valid_q   <= 1'b0;
      result_q  <= '0;
      cond_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_mul_c) begin
              state   <= ST_BUSY;
              valid_q <= 1'b0;
            end else begin
              state     <= ST_DONE;
              valid_q   <= 1'b1;
              result_q  <= res_c;
              illegal_q <= illegal_c;
              if (!illegal_c) cond_q <= flags_c;
            end
          end else if ((state == ST_DONE) && bus.out_ready) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            state     <= ST_DONE;
            valid_q   <= 1'b1;
            result_q  <= mul_prod[WIDTH-1:0];
            cond_q    <= mul_flags_c;
            illegal_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus  ();
  alu_seq_if #(.WIDTH(W)) bus0 ();

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  int checks = 0;
  int errors = 0;
  int cond_exp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference: value semantics of each opcode on 8-bit unsigned integers
  function automatic void model(input int op, input int a, input int b, input bit mul_en,
                                output int r, output int f, output bit ill, output int lat);
    int s;
    bit z, n, c, v;
    lat = 1; ill = 1'b0; c = 1'b0; v = 1'b0; r = 0;
    case (op)
      0: r = 0;
      1: begin
        s = a + b; r = s % 256; c = (s > 255);
        s = sx(a) + sx(b); v = (s > 127) || (s < -128);
      end
      2, 15: begin
        r = (a - b + 256) % 256; c = (a >= b);
        s = sx(a) - sx(b); v = (s > 127) || (s < -128);
      end
      3: begin r = (256 - b) % 256; c = (b == 0); v = (b == 128); end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = 255 - b;
      8: begin
        if (mul_en) begin
          s = a * b; r = s % 256; c = (s > 255); v = c; lat = int'(W) + 1;
        end else begin
          ill = 1'b1; r = 0;
        end
      end
      9:  r = b;
      10: begin r = (a * 2) % 256; c = (a >= 128); end
      11: begin r = a / 2; c = (a % 2) == 1; end
      12: begin r = (a * 2) % 256 + a / 128; c = (a >= 128); end
      13: begin r = a / 2 + (a % 2) * 128; c = (a % 2) == 1; end
      14: begin
        s = a + 4; r = s % 256; c = (s > 255);
        s = sx(a) + 4; v = (s > 127);
      end
      default: r = 0;
    endcase
    z = (r == 0);
    n = (r >= 128);
    if (op == 15) r = a;
    f = (z ? 8 : 0) + (n ? 4 : 0) + (c ? 2 : 0) + (v ? 1 : 0);
  endfunction

  // Issue one op (called at a negedge), wait for its result and check it
  task automatic run_op(input int op, input int a, input int b);
    int r, f, lat, n;
    bit ill, rdy, got_valid, busy_rdy;
    model(op, a, b, 1'b1, r, f, ill, lat);
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'(op);
    bus.a        = W'(a);
    bus.b        = W'(b);
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 20) begin
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (!rdy) @(negedge clk);
      n++;
    end
    check($sformatf("op%0h accept", op), 32'(rdy), 32'd1);
    bus.in_valid = 1'b0;
    n = 0;
    got_valid = 1'b0;
    busy_rdy = 1'b0;
    while (!got_valid && n < 40) begin
      @(negedge clk);
      n++;
      got_valid = bus.out_valid;
      if (!got_valid && bus.in_ready) busy_rdy = 1'b1;
    end
    if (!ill) cond_exp = f;
    check($sformatf("op%0h latency", op), 32'(n), 32'(lat));
    check($sformatf("op%0h a=%0h b=%0h result", op, a, b), 32'(bus.result), 32'(r));
    check($sformatf("op%0h a=%0h b=%0h cond", op, a, b), 32'(bus.cond), 32'(cond_exp));
    check($sformatf("op%0h illegal", op), 32'(bus.illegal), 32'(ill));
    if (lat > 1) check("busy in_ready", 32'(busy_rdy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ops[4], as[4], bs[4];
    int r, f, lat, hold_r, hold_c, spurious;
    bit ill;

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.alu_op = '0; bus.out_ready = 1'b1;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.alu_op = '0; bus0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    check("reset cond", 32'(bus.cond), 32'd0);
    check("reset illegal", 32'(bus.illegal), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases with hard constants
    run_op(1, 8'h7F, 8'h01);
    check("add7f result const", 32'(bus.result), 32'h80);
    check("add7f cond const", 32'(bus.cond), 32'b0101);
    run_op(2, 5, 5);
    check("sub55 cond const", 32'(bus.cond), 32'b1010);
    run_op(15, 3, 5);
    check("cmp35 result const", 32'(bus.result), 32'd3);
    check("cmp35 cond const", 32'(bus.cond), 32'b0100);
    run_op(8, 8'h10, 8'h11);
    check("mul result const", 32'(bus.result), 32'h10);
    check("mul cv const", 32'(bus.cond[1:0]), 32'b11);
    run_op(12, 8'h81, 0);
    check("rol result const", 32'(bus.result), 32'h03);
    check("rol c const", 32'(bus.cond[1]), 32'd1);
    run_op(3, 8'h80, 8'h80);
    run_op(3, 0, 0);
    run_op(14, 8'h7E, 0);

    // Back-to-back single-cycle ops, one result per cycle
    for (int i = 0; i < 4; i++) begin
      ops[i] = $urandom_range(0, 15);
      if (ops[i] == 8) ops[i] = 9;
      as[i] = $urandom_range(0, 255);
      bs[i] = $urandom_range(0, 255);
    end
    bus.in_valid = 1'b1; bus.alu_op = 4'(ops[0]); bus.a = W'(as[0]); bus.b = W'(bs[0]);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin
        bus.alu_op = 4'(ops[i+1]); bus.a = W'(as[i+1]); bus.b = W'(bs[i+1]);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      model(ops[i], as[i], bs[i], 1'b1, r, f, ill, lat);
      cond_exp = f;
      check($sformatf("b2b%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("b2b%0d result", i), 32'(bus.result), 32'(r));
      check($sformatf("b2b%0d cond", i), 32'(bus.cond), 32'(cond_exp));
    end

    // Stall in DONE with a competing request pending
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    run_op(6, $urandom_range(0, 255), $urandom_range(0, 255));
    hold_r = int'(bus.result);
    hold_c = cond_exp;
    bus.in_valid = 1'b1; bus.alu_op = 4'(1); bus.a = W'(8'hF0); bus.b = W'(8'h20);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("stall%0d result", k), 32'(bus.result), 32'(hold_r));
      check($sformatf("stall%0d cond", k), 32'(bus.cond), 32'(hold_c));
      check($sformatf("stall%0d in_ready", k), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    run_op(1, 8'hF0, 8'h20);

    // Reset in the middle of a multiply
    bus.in_valid = 1'b1; bus.alu_op = 4'(8); bus.a = W'(8'hFF); bus.b = W'(8'hFF);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    cond_exp = 0;
    check("midmul out_valid", 32'(bus.out_valid), 32'd0);
    check("midmul cond", 32'(bus.cond), 32'd0);
    check("midmul result", 32'(bus.result), 32'd0);
    check("midmul in_ready", 32'(bus.in_ready), 32'd1);
    spurious = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus.out_valid) spurious++;
    end
    check("midmul no output", 32'(spurious), 32'd0);

    // Random operations
    for (int i = 0; i < 150; i++)
      run_op($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));

    // MUL disabled: opcode 1000 is illegal and leaves cond alone
    bus0.in_valid = 1'b1; bus0.alu_op = 4'(2); bus0.a = W'(8'hF0); bus0.b = W'(8'h10);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    @(negedge clk);
    check("nomul sub result", 32'(bus0.result), 32'hE0);
    check("nomul sub cond", 32'(bus0.cond), 32'b0110);
    bus0.in_valid = 1'b1; bus0.alu_op = 4'(8); bus0.a = W'(8'h03); bus0.b = W'(8'h05);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    @(negedge clk);
    check("illegal out_valid", 32'(bus0.out_valid), 32'd1);
    check("illegal result", 32'(bus0.result), 32'd0);
    check("illegal flag", 32'(bus0.illegal), 32'd1);
    check("illegal cond kept", 32'(bus0.cond), 32'b0110);
    bus0.in_valid = 1'b1; bus0.alu_op = 4'(1); bus0.a = W'(8'h01); bus0.b = W'(8'h01);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    @(negedge clk);
    check("after illegal result", 32'(bus0.result), 32'd2);
    check("after illegal flag", 32'(bus0.illegal), 32'd0);
    check("after illegal cond", 32'(bus0.cond), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
